// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    PORT_IF,
    PORT_LS
  } port_id_e;

  // Counter width able to hold 0..limit inclusive.
  function automatic int unsigned streak_width(int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive load/store grants taken while fetch was waiting.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int unsigned CW = streak_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_streak;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (i_clr) begin
      r_streak <= '0;
    end else if (i_inc && (r_streak != LIMIT)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  assign o_at_limit = (r_streak == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and load/store,
// one outstanding transaction at a time, with a starvation guard for fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH       = 32,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [AWIDTH-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DWIDTH-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [AWIDTH-1:0]   ls_addr,
  input  logic [DWIDTH-1:0]   ls_wdata,
  input  logic [DWIDTH/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DWIDTH-1:0]   ls_rdata,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_wdata,
  output logic [DWIDTH/8-1:0] mem_be,
  input  logic                mem_rvalid,
  input  logic [DWIDTH-1:0]   mem_rdata,
  output logic                busy,
  output logic                err_spurious
);

  arb_state_e r_state, w_state_next;
  port_id_e   r_owner, w_owner_next;
  logic       r_killed, w_killed_next;
  logic       r_err_spurious;

  logic w_arb_ok, w_at_limit, w_if_win, w_ls_win, w_resp;
  logic w_unused_addr_lsbs;

  // Nothing is granted or returned while reset is held.
  assign w_arb_ok = (r_state == ARB_IDLE) && mem_ready && !reset;
  assign w_if_win = w_arb_ok && if_req && (!ls_req || w_at_limit);
  assign w_ls_win = w_arb_ok && ls_req && !w_if_win;
  assign w_resp   = (r_state == ARB_WAIT) && mem_rvalid && !reset;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_ls_win && if_req),
    .i_clr     (w_if_win || !if_req),
    .o_at_limit(w_at_limit)
  );

  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_killed_next = r_killed;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_if_win || w_ls_win) begin
          w_state_next  = ARB_WAIT;
          w_owner_next  = w_if_win ? PORT_IF : PORT_LS;
          w_killed_next = w_if_win && if_kill;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          w_state_next  = ARB_IDLE;
          w_killed_next = 1'b0;
        end else if ((r_owner == PORT_IF) && if_kill) begin
          w_killed_next = 1'b1;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ARB_IDLE;
      r_owner        <= PORT_LS;
      r_killed       <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_owner        <= w_owner_next;
      r_killed       <= w_killed_next;
      r_err_spurious <= r_err_spurious || ((r_state == ARB_IDLE) && mem_rvalid);
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (w_if_win) begin
      mem_req  = 1'b1;
      mem_addr = {if_addr[AWIDTH-1:2], 2'b00};
      mem_be   = '1;
    end else if (w_ls_win) begin
      mem_req   = 1'b1;
      mem_we    = ls_we;
      mem_addr  = {ls_addr[AWIDTH-1:2], 2'b00};
      mem_wdata = ls_wdata;
      mem_be    = ls_be;
    end
  end

  assign if_gnt    = w_if_win;
  assign ls_gnt    = w_ls_win;
  // A kill arriving together with the response still suppresses it.
  assign if_rvalid = w_resp && (r_owner == PORT_IF) && !r_killed && !if_kill;
  assign ls_rvalid = w_resp && (r_owner == PORT_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

  assign busy         = (r_state == ARB_WAIT);
  assign err_spurious = r_err_spurious;

  assign w_unused_addr_lsbs = ^{if_addr[1:0], ls_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam logic [31:0] KEY = 32'h5A5A_0F0F;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req, if_kill, if_gnt, if_rvalid;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata, ls_rdata;
  logic [DW/8-1:0] ls_be;
  logic            mem_ready, mem_req, mem_we, mem_rvalid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_be;
  logic            busy, err_spurious;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AWIDTH      (AW),
    .DWIDTH      (DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_kill     (if_kill),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .ls_req      (ls_req),
    .ls_we       (ls_we),
    .ls_addr     (ls_addr),
    .ls_wdata    (ls_wdata),
    .ls_be       (ls_be),
    .ls_gnt      (ls_gnt),
    .ls_rvalid   (ls_rvalid),
    .ls_rdata    (ls_rdata),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .err_spurious(err_spurious)
  );

  task automatic idle_in();
    if_req = 0; if_addr = '0; if_kill = 0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    mem_ready = 1; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1; if_req = 1; ls_req = 1; mem_rvalid = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_total++;
    if ({if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, busy, err_spurious} !== 7'b0) begin
      $display("FAIL reset_held: flags=%b required 0000000",
               {if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, busy, err_spurious});
    end else n_pass++;
    next_cycle();
    idle_in();
    reset = 0;
    @(negedge clk);
    n_total++;
    if ({if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, busy, err_spurious, if_rdata, ls_rdata}
        !== '0) begin
      $display("FAIL reset_release: flags=%b if_rdata=%h ls_rdata=%h required all zero",
               {if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, busy, err_spurious},
               if_rdata, ls_rdata);
    end else n_pass++;
  endtask

  task automatic test_fetch_basic();
    do_reset();
    if_req = 1; if_addr = 32'h0100_0000;
    @(negedge clk);
    n_total++;
    if ({if_gnt, ls_gnt, mem_req, mem_we} !== 4'b1010) begin
      $display("FAIL fetch_grant: gnt/req/we=%b required 1010", {if_gnt, ls_gnt, mem_req, mem_we});
    end else n_pass++;
    n_total++;
    if ({mem_addr, mem_be} !== {32'h0100_0000, 4'hF}) begin
      $display("FAIL fetch_bus: addr=%h be=%h required 01000000/f", mem_addr, mem_be);
    end else n_pass++;
    next_cycle();
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    n_total++;
    if ({if_gnt, if_rvalid, ls_rvalid, busy, if_rdata} !== {4'b0101, 32'h1234_5678}) begin
      $display("FAIL fetch_resp: gnt/rv/lsrv/busy=%b rdata=%h required 0101/12345678",
               {if_gnt, if_rvalid, ls_rvalid, busy}, if_rdata);
    end else n_pass++;
    next_cycle();
    mem_rvalid = 0; mem_rdata = '0; if_req = 1; if_addr = 32'h0100_0004;
    @(negedge clk);
    n_total++;
    if ({if_gnt, busy} !== 2'b10) begin
      $display("FAIL fetch_regrant: gnt/busy=%b required 10", {if_gnt, busy});
    end else n_pass++;
    next_cycle();
    if_req = 0; mem_rvalid = 1;
    next_cycle();
    mem_rvalid = 0;
  endtask

  task automatic test_starve();
    do_reset();
    if_req = 1; if_addr = 32'h0100_0000;
    ls_req = 1; ls_addr = 32'h0100_0104; ls_be = 4'hF;
    for (int k = 0; k < LIM + 2; k++) begin
      @(negedge clk);
      n_total++;
      if ({if_gnt, ls_gnt} !== ((k == LIM) ? 2'b10 : 2'b01)) begin
        $display("FAIL starve_arb%0d: if_gnt/ls_gnt=%b required %b", k, {if_gnt, ls_gnt},
                 (k == LIM) ? 2'b10 : 2'b01);
      end else n_pass++;
      if (k == 0) begin
        n_total++;
        if (mem_addr !== 32'h0100_0104) begin
          $display("FAIL starve_addr: addr=%h required 01000104", mem_addr);
        end else n_pass++;
      end
      next_cycle();
      mem_rvalid = 1;
      next_cycle();
      mem_rvalid = 0;
    end
    idle_in();
    next_cycle();
  endtask

  task automatic test_store();
    do_reset();
    ls_req = 1; ls_we = 1; ls_addr = 32'h0100_0203; ls_be = 4'b0011; ls_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_total++;
    if ({mem_req, mem_we, ls_gnt, if_gnt} !== 4'b1110) begin
      $display("FAIL store_grant: req/we/lsg/ifg=%b required 1110",
               {mem_req, mem_we, ls_gnt, if_gnt});
    end else n_pass++;
    n_total++;
    if ({mem_addr, mem_be, mem_wdata} !== {32'h0100_0200, 4'b0011, 32'hCAFE_F00D}) begin
      $display("FAIL store_bus: addr=%h be=%b wdata=%h required 01000200/0011/cafef00d",
               mem_addr, mem_be, mem_wdata);
    end else n_pass++;
    next_cycle();
    ls_req = 0;
    @(negedge clk);
    n_total++;
    if ({ls_rvalid, busy} !== 2'b01) begin
      $display("FAIL store_wait: rv/busy=%b required 01", {ls_rvalid, busy});
    end else n_pass++;
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    n_total++;
    if ({ls_rvalid, if_rvalid, if_rdata} !== {2'b10, 32'h0}) begin
      $display("FAIL store_ack: lsrv/ifrv=%b if_rdata=%h required 10/0",
               {ls_rvalid, if_rvalid}, if_rdata);
    end else n_pass++;
    next_cycle();
    mem_rvalid = 0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) begin
      $display("FAIL store_done: busy=%b required 0", busy);
    end else n_pass++;
  endtask

  task automatic test_kill();
    do_reset();
    if_req = 1; if_addr = 32'h0100_0040;
    @(negedge clk);
    n_total++;
    if (if_gnt !== 1'b1) begin
      $display("FAIL kill_grant: if_gnt=%b required 1", if_gnt);
    end else n_pass++;
    next_cycle();
    if_req = 0; if_kill = 1; ls_req = 1; ls_addr = 32'h0100_0010; ls_be = 4'hF;
    @(negedge clk);
    n_total++;
    if ({ls_gnt, busy} !== 2'b01) begin
      $display("FAIL kill_c1: ls_gnt/busy=%b required 01", {ls_gnt, busy});
    end else n_pass++;
    next_cycle();
    if_kill = 0;
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    n_total++;
    if ({if_rvalid, ls_rvalid, busy, ls_gnt, if_rdata} !== {4'b0010, 32'h0}) begin
      $display("FAIL kill_c3: ifrv/lsrv/busy/lsg=%b if_rdata=%h required 0010/0",
               {if_rvalid, ls_rvalid, busy, ls_gnt}, if_rdata);
    end else n_pass++;
    next_cycle();
    mem_rvalid = 0;
    @(negedge clk);
    n_total++;
    if ({ls_gnt, busy} !== 2'b10) begin
      $display("FAIL kill_c4: ls_gnt/busy=%b required 10", {ls_gnt, busy});
    end else n_pass++;
    next_cycle();
    // Kill while a load is outstanding must not touch its response.
    ls_req = 0; if_kill = 1; mem_rvalid = 1; mem_rdata = 32'h0000_1111;
    @(negedge clk);
    n_total++;
    if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h0000_1111}) begin
      $display("FAIL kill_noeffect: ls_rvalid=%b ls_rdata=%h required 1/00001111",
               ls_rvalid, ls_rdata);
    end else n_pass++;
    next_cycle();
    if_kill = 0; mem_rvalid = 0; if_req = 1;
    next_cycle();
    if_req = 0; if_kill = 1; mem_rvalid = 1;
    @(negedge clk);
    n_total++;
    if ({if_rvalid, busy} !== 2'b01) begin
      $display("FAIL kill_same_cycle: if_rvalid/busy=%b required 01", {if_rvalid, busy});
    end else n_pass++;
    next_cycle();
    idle_in();
  endtask

  task automatic test_not_ready();
    do_reset();
    mem_ready = 0; if_req = 1; ls_req = 1; if_addr = 32'h0100_0000; ls_addr = 32'h0100_0020;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if ({if_gnt, ls_gnt, mem_req} !== 3'b000) begin
        $display("FAIL not_ready%0d: ifg/lsg/req=%b required 000", k, {if_gnt, ls_gnt, mem_req});
      end else n_pass++;
      next_cycle();
    end
    mem_ready = 1;
    @(negedge clk);
    n_total++;
    if ({if_gnt, ls_gnt, mem_req} !== 3'b011) begin
      $display("FAIL ready_grant: ifg/lsg/req=%b required 011", {if_gnt, ls_gnt, mem_req});
    end else n_pass++;
    next_cycle();
    idle_in();
    mem_rvalid = 1;
    next_cycle();
    mem_rvalid = 0;
  endtask

  task automatic test_random();
    bit m_busy, m_owner_if, m_killed, m_load, pend_if, pend_ls, gi, gl, e_ifrv, e_lsrv;
    int m_streak, resp_cnt;
    logic [31:0] out_addr, if_a, ls_a, ls_d;
    logic ls_w;
    logic [3:0] ls_b;
    do_reset();
    m_busy = 0; m_owner_if = 0; m_killed = 0; m_load = 0; pend_if = 0; pend_ls = 0;
    m_streak = 0; resp_cnt = 0; out_addr = '0;
    if_a = '0; ls_a = '0; ls_d = '0; ls_w = 0; ls_b = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend_if && ($urandom_range(0, 3) != 0)) begin
        pend_if = 1; if_a = $urandom;
      end
      if (!pend_ls && ($urandom_range(0, 1) != 0)) begin
        pend_ls = 1; ls_a = $urandom; ls_d = $urandom;
        ls_w = 1'($urandom_range(0, 1)); ls_b = 4'($urandom);
      end
      if_req = pend_if; if_addr = if_a;
      ls_req = pend_ls; ls_addr = ls_a; ls_wdata = ls_d; ls_we = ls_w; ls_be = ls_b;
      mem_ready = ($urandom_range(0, 3) != 0);
      if_kill = ($urandom_range(0, 7) == 0);
      mem_rvalid = m_busy && (resp_cnt == 0);
      mem_rdata = mem_rvalid ? (out_addr ^ KEY) : 32'($urandom);
      @(negedge clk);
      gi = !m_busy && mem_ready && pend_if && (!pend_ls || (m_streak == LIM));
      gl = !m_busy && mem_ready && pend_ls && !gi;
      e_ifrv = m_busy && m_owner_if && mem_rvalid && !m_killed && !if_kill;
      e_lsrv = m_busy && !m_owner_if && mem_rvalid;
      n_total++;
      if ({if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, busy} !==
          {gi, gl, gi | gl, e_ifrv, e_lsrv, m_busy}) begin
        $display("FAIL rand_flags@%0d: ifg/lsg/req/ifrv/lsrv/busy=%b required %b", cyc,
                 {if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, busy},
                 {gi, gl, gi | gl, e_ifrv, e_lsrv, m_busy});
      end else n_pass++;
      if (gi) begin
        n_total++;
        if ({mem_addr, mem_we, mem_be} !== {if_a & 32'hFFFF_FFFC, 1'b0, 4'hF}) begin
          $display("FAIL rand_if_bus@%0d: addr=%h we=%b be=%h required %h/0/f", cyc,
                   mem_addr, mem_we, mem_be, if_a & 32'hFFFF_FFFC);
        end else n_pass++;
      end
      if (gl) begin
        n_total++;
        if ({mem_addr, mem_we, mem_be, mem_wdata} !== {ls_a & 32'hFFFF_FFFC, ls_w, ls_b, ls_d})
        begin
          $display("FAIL rand_ls_bus@%0d: addr=%h we=%b be=%h wd=%h required %h/%b/%h/%h", cyc,
                   mem_addr, mem_we, mem_be, mem_wdata, ls_a & 32'hFFFF_FFFC, ls_w, ls_b, ls_d);
        end else n_pass++;
      end
      if (e_ifrv) begin
        n_total++;
        if (if_rdata !== (out_addr ^ KEY)) begin
          $display("FAIL rand_if_rdata@%0d: %h required %h", cyc, if_rdata, out_addr ^ KEY);
        end else n_pass++;
      end
      if (e_lsrv && m_load) begin
        n_total++;
        if (ls_rdata !== (out_addr ^ KEY)) begin
          $display("FAIL rand_ls_rdata@%0d: %h required %h", cyc, ls_rdata, out_addr ^ KEY);
        end else n_pass++;
      end
      if (m_busy && mem_rvalid) begin
        n_total++;
        if ((m_owner_if ? ls_rdata : if_rdata) !== 32'h0) begin
          $display("FAIL rand_nonowner_rdata@%0d: %h required 0", cyc,
                   m_owner_if ? ls_rdata : if_rdata);
        end else n_pass++;
      end
      if (m_busy) begin
        if (mem_rvalid) begin
          m_busy = 0; m_killed = 0;
        end else begin
          if (m_owner_if && if_kill) m_killed = 1;
          resp_cnt--;
        end
      end else if (gi || gl) begin
        m_busy = 1; m_owner_if = gi; m_killed = gi && if_kill;
        resp_cnt = $urandom_range(0, 2);
        out_addr = (gi ? if_a : ls_a) & 32'hFFFF_FFFC;
        m_load = gl && !ls_w;
      end
      if (!pend_if || gi) m_streak = 0;
      else if (gl && (m_streak < LIM)) m_streak++;
      if (gi) pend_if = 0;
      if (gl) pend_ls = 0;
      next_cycle();
    end
    idle_in();
    @(negedge clk);
    n_total++;
    if (err_spurious !== 1'b0) begin
      $display("FAIL rand_no_spurious: err_spurious=%b required 0", err_spurious);
    end else n_pass++;
  endtask

  task automatic test_spurious();
    do_reset();
    ls_req = 1; ls_addr = 32'h0100_0300; ls_be = 4'hF;
    next_cycle();
    ls_req = 0; reset = 1;
    next_cycle();
    reset = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    n_total++;
    if ({if_rvalid, ls_rvalid, busy, err_spurious, ls_rdata} !== {4'b0000, 32'h0}) begin
      $display("FAIL spurious_drop: ifrv/lsrv/busy/err=%b ls_rdata=%h required 0000/0",
               {if_rvalid, ls_rvalid, busy, err_spurious}, ls_rdata);
    end else n_pass++;
    next_cycle();
    mem_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if ({err_spurious, busy} !== 2'b10) begin
        $display("FAIL spurious_sticky%0d: err/busy=%b required 10", k, {err_spurious, busy});
      end else n_pass++;
      next_cycle();
    end
    reset = 1;
    next_cycle();
    reset = 0;
    @(negedge clk);
    n_total++;
    if (err_spurious !== 1'b0) begin
      $display("FAIL spurious_clear: err_spurious=%b required 0", err_spurious);
    end else n_pass++;
  endtask

  initial begin
    idle_in();
    reset = 1;
    test_reset();
    test_fetch_basic();
    test_starve();
    test_store();
    test_kill();
    test_not_ready();
    test_random();
    test_spurious();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage and the load/store (memory) stage of the RV32I core.
- Accepts one request at a time, tracks the outstanding transaction and routes the response back to its owner.
- Gives the load/store port priority, with a starvation guard for fetch.
- Sits between pipeline fetch/memory stages and the memory model; the pipeline stalls on missing grant or missing response.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- STARVE_LIMIT, 4, max consecutive load/store grants while fetch waits (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  AWIDTH  fetch address
- if_kill  in  1  discard response of outstanding fetch (branch redirect)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid, one cycle
- if_rdata  out  DWIDTH  fetch data
- ls_req  in  1  load/store request, held until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  AWIDTH  load/store address
- ls_wdata  in  DWIDTH  store data
- ls_be  in  DWIDTH/8  byte enables
- ls_gnt  out  1  load/store accepted this cycle
- ls_rvalid  out  1  load data / store ack, one cycle
- ls_rdata  out  DWIDTH  load data
- mem_ready  in  1  memory can accept a request
- mem_req  out  1  request to memory
- mem_we  out  1  write enable
- mem_addr  out  AWIDTH  word-aligned address
- mem_wdata  out  DWIDTH  write data
- mem_be  out  DWIDTH/8  byte enables; all ones for fetch
- mem_rvalid  in  1  memory response valid, in order, >=1 cycle after accept
- mem_rdata  in  DWIDTH  response data
- busy  out  1  transaction outstanding
- err_spurious  out  1  sticky; mem_rvalid seen while IDLE

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state = IDLE, owner = LS, streak = 0, killed = 0, err_spurious = 0. All gnt, rvalid and mem_req outputs are 0.
- Reset mid-transaction abandons it. A late mem_rvalid arriving in IDLE is dropped and sets err_spurious.
- FSM states: IDLE, WAIT_RESP.
- IDLE:
  - If mem_ready and (if_req or ls_req), select a winner.
  - Assert mem_req and the winner's gnt combinationally in the same cycle.
  - Latch owner; next state is WAIT_RESP.
  - No request, or mem_ready = 0: stay in IDLE, all gnt = 0.
- Arbitration:
  - ls wins unless if_req and streak == STARVE_LIMIT; then fetch wins.
  - streak increments, saturating, on an ls grant while if_req = 1.
  - streak clears on a fetch grant, or in any cycle with if_req = 0.
- mem_addr = {winner addr[AWIDTH-1:2], 2'b00}.
  - Fetch: mem_we = 0, mem_be = all ones.
  - Load/store: ls_we and ls_be pass through; mem_wdata = ls_wdata.
- WAIT_RESP:
  - mem_req = 0, no grants.
  - On mem_rvalid: owner's rvalid = 1 combinationally; rdata = mem_rdata (valid only while rvalid). Return to IDLE.
  - The next grant is possible in the following cycle at the earliest, so minimum 2 cycles per access.
- Store ack: ls_rvalid pulses on the store's mem_rvalid; ls_rdata is don't-care.
- Kill:
  - if_kill in the grant cycle of a fetch, or in WAIT_RESP with owner = IF, sets killed.
  - A killed response is consumed: FSM returns to IDLE and if_rvalid stays 0.
  - if_kill coinciding with mem_rvalid suppresses that response.
  - if_kill with no fetch outstanding has no effect. killed clears on leaving WAIT_RESP.
- busy = (state == WAIT_RESP).
- Non-owner rdata outputs hold 0; non-owner rvalid is always 0.

Decomposition:
- Shared package (core package alongside constants.svh) holds:
  - typedef enum arb_state_e {ARB_IDLE, ARB_WAIT};
  - typedef enum port_id_e {PORT_IF, PORT_LS}.
- Sub-module arb_starve_ctr: saturating streak counter, with inputs inc/clr and output at_limit.
- FSM, mux and response routing stay in the top module.

Test Plan:
- Fetch only, mem_ready = 1, response latency 1: if_req @0x01000000 -> cycle 0 if_gnt = 1, mem_addr = 0x01000000, mem_be = 4'hF; cycle 1 if_rvalid = 1 with mem_rdata; next grant no earlier than cycle 2.
- Simultaneous if_req and ls_req (load @0x01000104), STARVE_LIMIT = 4, both held:
  - ls granted 4 times in a row, then fetch granted on the 5th arbitration;
  - streak reset afterwards.
- Store ls_we = 1, ls_addr = 0x01000203, ls_be = 4'b0011 -> mem_addr = 0x01000200, mem_we = 1, mem_be = 4'b0011; ls_rvalid pulses on mem_rvalid.
- Fetch granted, if_kill in cycle 1, mem_rvalid in cycle 3 -> if_rvalid stays 0; busy drops after cycle 3; pending ls_req granted in cycle 4.
- mem_ready = 0 for 3 cycles with both requests held -> no gnt and no mem_req; ls granted in the first cycle mem_ready = 1.
- reset asserted in WAIT_RESP, then mem_rvalid in IDLE -> outputs at reset values, no rvalid, err_spurious = 1 until the next reset.
